// File: rtl/hash_engine_ch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hash_engine_ch_arbiter_pkg
//  Brief    : Shared defaults, FSM state encoding and helpers for the
//             multi-channel hash engine arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 8
`endif

package hash_engine_ch_arbiter_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int TAG_DEPTH_DEF = 8;
    localparam int DATA_W_DEF    = `HASH_ISSUE_WIDTH * 8;

    // Arbiter FSM: IDLE picks the next channel, LOCKED streams its job.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Single-step modulo for an index that is known to be below 2*n.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hash_engine_ch_arbiter_ch_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ch_tag_fifo
//  Brief    : In-order channel-id tag FIFO. A pop frees a slot in the same
//             cycle, so a push while full is accepted when a pop coincides.
//  Revision : 1.0 - initial release
// ============================================================================
module ch_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer MSB separates the full and empty cases.
    assign full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign head      = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    // Pointer update; both pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/hash_engine_ch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hash_engine_ch_arbiter
//  Brief    : Grants one input channel at a time for a whole job into a
//             shared in-order hash engine and tags engine results with the
//             owning channel id via an in-order tag FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module hash_engine_ch_arbiter
    import hash_engine_ch_arbiter_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF,
    parameter int TAG_PTR_W = $clog2(TAG_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TAG_PTR_W:0]       cfg_max_jobs,
    input  logic [NUM_CH-1:0]        ch_i_valid,
    output logic [NUM_CH-1:0]        ch_i_ready,
    input  logic [NUM_CH-1:0]        ch_i_delim,
    input  logic [NUM_CH*DATA_W-1:0] ch_i_data,
    output logic                     e_i_valid,
    input  logic                     e_i_ready,
    output logic                     e_i_delim,
    output logic [DATA_W-1:0]        e_i_data,
    input  logic                     e_o_valid,
    input  logic                     e_o_delim,
    output logic                     e_o_ready,
    output logic                     o_valid,
    output logic [CH_W-1:0]          o_ch_id,
    input  logic                     o_ready,
    output logic [TAG_PTR_W:0]       inflight,
    output logic                     err_tag_underflow
);

    localparam logic [TAG_PTR_W:0] C_DEPTH = (TAG_PTR_W+1)'(TAG_DEPTH);

    arb_state_t        r_state;
    logic [CH_W-1:0]   r_grant_id;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_err;

    logic              w_ret_accept;
    logic              w_pop;
    logic              w_push;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CH_W-1:0]   w_head;
    logic [TAG_PTR_W:0] w_count;
    logic [TAG_PTR_W:0] w_eff_max;
    logic [TAG_PTR_W:0] w_occ_after_pop;
    logic              w_eligible;
    logic [CH_W-1:0]   w_idx;
    logic [CH_W-1:0]   w_pick;
    logic              w_pick_found;
    logic              w_job_done;

    // Return path is a zero-latency pass-through tagged by the FIFO head.
    assign o_valid           = e_o_valid;
    assign e_o_ready         = o_ready;
    assign w_ret_accept      = e_o_valid & o_ready;
    assign w_pop             = w_ret_accept & e_o_delim & ~w_fifo_empty;
    assign o_ch_id           = w_fifo_empty ? '0 : w_head;
    assign inflight          = w_count;
    assign err_tag_underflow = r_err;

    // A slot freed by a same-cycle pop is usable by the grant.
    assign w_eff_max       = (cfg_max_jobs == '0) ? C_DEPTH : cfg_max_jobs;
    assign w_occ_after_pop = w_count - (TAG_PTR_W+1)'(w_pop);
    assign w_eligible      = (|ch_i_valid) && (w_occ_after_pop < w_eff_max) &&
                             (~w_fifo_full | w_pop);
    assign w_push          = (r_state == ST_IDLE) && w_eligible;
    assign w_job_done      = ch_i_valid[r_grant_id] & e_i_ready & ch_i_delim[r_grant_id];

    // Round-robin scan starting at rr_ptr for the first valid channel.
    always_comb begin
        w_idx        = '0;
        w_pick       = '0;
        w_pick_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = CH_W'(wrap_idx(int'(r_rr_ptr) + i, NUM_CH));
            if (!w_pick_found && ch_i_valid[w_idx]) begin
                w_pick       = w_idx;
                w_pick_found = 1'b1;
            end
        end
    end

    // Forward path: only the granted channel talks to the engine while locked.
    always_comb begin
        ch_i_ready = '0;
        e_i_valid  = 1'b0;
        e_i_delim  = 1'b0;
        e_i_data   = '0;
        if (r_state == ST_LOCKED) begin
            e_i_valid              = ch_i_valid[r_grant_id];
            e_i_delim              = ch_i_delim[r_grant_id];
            e_i_data               = ch_i_data[r_grant_id*DATA_W +: DATA_W];
            ch_i_ready[r_grant_id] = e_i_ready;
        end
    end

    // Job-level grant FSM; a job is held until its delim beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_eligible) begin
                        r_grant_id <= w_pick;
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_job_done) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= (r_grant_id == CH_W'(NUM_CH - 1)) ?
                                    '0 : r_grant_id + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flag for a result beat that had no owning tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_err <= 1'b0;
        else if (w_ret_accept && w_fifo_empty)  r_err <= 1'b1;
    end

    ch_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (TAG_DEPTH),
        .PTR_W (TAG_PTR_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_pick),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_hash_engine_ch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hash_engine_ch_arbiter
//  Brief    : Randomized self-checking bench with a job-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hash_engine_ch_arbiter;
    import hash_engine_ch_arbiter_pkg::*;

    localparam int N  = NUM_CH_DEF;
    localparam int CW = $clog2(N);
    localparam int DW = DATA_W_DEF;
    localparam int D  = TAG_DEPTH_DEF;
    localparam int PW = $clog2(D);

    logic              clk;
    logic              rst;
    logic [PW:0]       cfg_max_jobs;
    logic [N-1:0]      ch_i_valid;
    logic [N-1:0]      ch_i_ready;
    logic [N-1:0]      ch_i_delim;
    logic [N*DW-1:0]   ch_i_data;
    logic              e_i_valid;
    logic              e_i_ready;
    logic              e_i_delim;
    logic [DW-1:0]     e_i_data;
    logic              e_o_valid;
    logic              e_o_delim;
    logic              e_o_ready;
    logic              o_valid;
    logic [CW-1:0]     o_ch_id;
    logic              o_ready;
    logic [PW:0]       inflight;
    logic              err_tag_underflow;

    hash_engine_ch_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_max_jobs      (cfg_max_jobs),
        .ch_i_valid        (ch_i_valid),
        .ch_i_ready        (ch_i_ready),
        .ch_i_delim        (ch_i_delim),
        .ch_i_data         (ch_i_data),
        .e_i_valid         (e_i_valid),
        .e_i_ready         (e_i_ready),
        .e_i_delim         (e_i_delim),
        .e_i_data          (e_i_data),
        .e_o_valid         (e_o_valid),
        .e_o_delim         (e_o_delim),
        .e_o_ready         (e_o_ready),
        .o_valid           (o_valid),
        .o_ch_id           (o_ch_id),
        .o_ready           (o_ready),
        .inflight          (inflight),
        .err_tag_underflow (err_tag_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: job owner, round-robin start, outstanding tag queue.
    bit m_locked = 0;
    int m_owner  = 0;
    int m_rr     = 0;
    int m_tags[$];
    bit m_err    = 0;
    int eng_jobs = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs already driven at a falling edge; check, advance model, next edge.
    task automatic step();
        logic [N-1:0] exp_ready;
        bit           exp_ev;
        bit           pop;
        int           eff;
        int           occ;
        int           pick;
        #1;
        exp_ready = '0;
        if (m_locked && e_i_ready) exp_ready[m_owner] = 1'b1;
        exp_ev = m_locked && ch_i_valid[m_owner];
        check("ch_i_ready", 64'(ch_i_ready), 64'(exp_ready));
        check("e_i_valid", 64'(e_i_valid), 64'(exp_ev));
        if (exp_ev) begin
            check("e_i_data", 64'(e_i_data), 64'(ch_i_data[m_owner*DW +: DW]));
            check("e_i_delim", 64'(e_i_delim), 64'(ch_i_delim[m_owner]));
        end
        check("o_valid", 64'(o_valid), 64'(e_o_valid));
        check("e_o_ready", 64'(e_o_ready), 64'(o_ready));
        check("o_ch_id", 64'(o_ch_id), (m_tags.size() == 0) ? 64'd0 : 64'(m_tags[0]));
        check("inflight", 64'(inflight), 64'(m_tags.size()));
        check("err_tag_underflow", 64'(err_tag_underflow), 64'(m_err));

        pop = e_o_valid && o_ready && e_o_delim && (m_tags.size() > 0);
        if (e_o_valid && o_ready && m_tags.size() == 0) m_err = 1;
        if (pop) m_tags.delete(0);
        if (e_o_valid && o_ready && e_o_delim && eng_jobs > 0) eng_jobs--;
        if (!m_locked) begin
            eff = (cfg_max_jobs == 0) ? D : int'(cfg_max_jobs);
            occ = m_tags.size();
            if (ch_i_valid != '0 && occ < eff && occ < D) begin
                pick = 0;
                for (int k = 0; k < N; k++) begin
                    if (ch_i_valid[(m_rr + k) % N]) begin
                        pick = (m_rr + k) % N;
                        break;
                    end
                end
                m_owner  = pick;
                m_locked = 1;
                m_tags.push_back(pick);
            end
        end else if (ch_i_valid[m_owner] && e_i_ready && ch_i_delim[m_owner]) begin
            m_locked = 0;
            m_rr     = (m_owner + 1) % N;
            eng_jobs++;
        end
        @(negedge clk);
    endtask

    task automatic drive_random(input int vpct, input int opct);
        for (int c = 0; c < N; c++) begin
            ch_i_valid[c] = ($urandom_range(99) < vpct);
            ch_i_delim[c] = ($urandom_range(2) == 0);
        end
        for (int w = 0; w < (N * DW) / 32; w++) ch_i_data[w*32 +: 32] = $urandom;
        e_i_ready = ($urandom_range(99) < 75);
        o_ready   = ($urandom_range(99) < 80);
        e_o_valid = (eng_jobs > 0) && ($urandom_range(99) < opct);
        e_o_delim = ($urandom_range(1) == 1);
    endtask

    initial begin
        rst          = 1'b1;
        cfg_max_jobs = '0;
        ch_i_valid   = '0;
        ch_i_delim   = '0;
        ch_i_data    = '0;
        e_i_ready    = 1'b0;
        e_o_valid    = 1'b0;
        e_o_delim    = 1'b0;
        o_ready      = 1'b0;

        // Outputs while held in reset.
        #7;
        check("rst_ch_i_ready", 64'(ch_i_ready), 64'd0);
        check("rst_e_i_valid", 64'(e_i_valid), 64'd0);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_err", 64'(err_tag_underflow), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Random phases; every third phase starves the result path to fill tags.
        for (int ph = 0; ph < 12; ph++) begin
            cfg_max_jobs = (PW+1)'($urandom_range(D, 0));
            for (int cy = 0; cy < 300; cy++) begin
                drive_random(70, (ph % 3 == 0) ? 5 : 60);
                step();
            end
        end

        // Finish the open job and drain all results.
        for (int cy = 0; cy < 400 && (m_locked || m_tags.size() > 0); cy++) begin
            ch_i_valid = '0;
            ch_i_delim = '1;
            if (m_locked) ch_i_valid[m_owner] = 1'b1;
            e_i_ready = 1'b1;
            o_ready   = 1'b1;
            e_o_valid = (eng_jobs > 0);
            e_o_delim = 1'b1;
            step();
        end
        check("drain_inflight", 64'(inflight), 64'd0);

        // Result delim with no tag outstanding: sticky error, id 0.
        ch_i_valid = '0;
        e_o_valid  = 1'b1;
        e_o_delim  = 1'b1;
        o_ready    = 1'b1;
        step();
        e_o_valid = 1'b0;
        step();
        step();
        check("err_sticky", 64'(err_tag_underflow), 64'd1);

        // Lock channel 1 mid-job, then reset between clock edges.
        ch_i_valid = N'(2);
        ch_i_delim = '0;
        e_i_ready  = 1'b1;
        step();
        step();
        check("lock_ch1", 64'(ch_i_ready), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_ch_i_ready", 64'(ch_i_ready), 64'd0);
        check("arst_e_i_valid", 64'(e_i_valid), 64'd0);
        check("arst_inflight", 64'(inflight), 64'd0);
        check("arst_err", 64'(err_tag_underflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
